// File: rtl/rc6_control_seq_if.sv
// rtl/rc6_control_seq_if.sv - request/strobe bundle between the write port and the RC6 sequencer
interface rc6_control_seq_if #(
    parameter int ROUNDS = 20
);
    localparam int RW = $clog2(ROUNDS + 1);

    logic          key_wr;
    logic          data_wr;
    logic          decrypt;
    logic          key_ext_wr;
    logic          key_int_wr;
    logic          data_ext_wr;
    logic          data_int_wr;
    logic          mode1;
    logic          mode2;
    logic [RW-1:0] round_idx;
    logic          decrypt_lat;
    logic          key_valid;
    logic          done;
    logic          error;
    logic          busy;

    modport master (
        output key_wr, data_wr, decrypt,
        input  key_ext_wr, key_int_wr, data_ext_wr, data_int_wr, mode1, mode2,
               round_idx, decrypt_lat, key_valid, done, error, busy
    );

    modport slave (
        input  key_wr, data_wr, decrypt,
        output key_ext_wr, key_int_wr, data_ext_wr, data_int_wr, mode1, mode2,
               round_idx, decrypt_lat, key_valid, done, error, busy
    );
endinterface

// File: rtl/rc6_control_seq.sv
// rtl/rc6_control_seq.sv - parametrised RC6 key-schedule / data-round strobe sequencer
module rc6_control_seq #(
    parameter int ROUNDS    = 20,
    parameter int KEY_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    rc6_control_seq_if.slave  bus
);
    localparam int ROUND_SPAN = 2 * ROUNDS + 4;
    localparam int SCHED      = 3 * ((KEY_WORDS > ROUND_SPAN) ? KEY_WORDS : ROUND_SPAN);
    localparam int CW         = $clog2(SCHED + 1);
    localparam int RW         = $clog2(ROUNDS + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCHED = 2'd1,
        ST_ROUND = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [RW-1:0] round;
    logic          pending;
    logic          key_valid;
    logic          decrypt_lat;
    logic          done;
    logic          error;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            count       <= '0;
            round       <= '0;
            pending     <= 1'b0;
            key_valid   <= 1'b0;
            decrypt_lat <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.key_wr) begin
                        state       <= ST_SCHED;
                        count       <= CW'(1);
                        key_valid   <= 1'b0;
                        pending     <= bus.data_wr;
                        decrypt_lat <= bus.decrypt;
                    end else if (bus.data_wr) begin
                        // Data-only requests reuse the stored schedule; without one they are refused.
                        if (key_valid) begin
                            state       <= ST_ROUND;
                            round       <= RW'(1);
                            decrypt_lat <= bus.decrypt;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                ST_SCHED: begin
                    if (count == CW'(SCHED)) begin
                        count     <= '0;
                        key_valid <= 1'b1;
                        pending   <= 1'b0;
                        if (pending) begin
                            state <= ST_ROUND;
                            round <= RW'(1);
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                ST_ROUND: begin
                    if (round == RW'(ROUNDS)) begin
                        state <= ST_IDLE;
                        round <= '0;
                        done  <= 1'b1;
                    end else begin
                        round <= round + RW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic accept_idle;
    assign accept_idle = (state == ST_IDLE) && !rst;

    always_comb begin
        bus.key_ext_wr  = accept_idle && bus.key_wr;
        bus.data_ext_wr = accept_idle && bus.data_wr && (bus.key_wr || key_valid);
        bus.key_int_wr  = (state == ST_SCHED);
        bus.data_int_wr = (state == ST_ROUND);
        bus.mode1       = (state == ST_ROUND) && (round == RW'(1));
        bus.mode2       = (state == ST_ROUND) && (round == RW'(ROUNDS));
        bus.round_idx   = '0;
        // Decryption walks the round keys backwards: index = ROUNDS+1-round.
        if (state == ST_ROUND)
            bus.round_idx = decrypt_lat ? (RW'(ROUNDS + 1) - round) : round;
        bus.decrypt_lat = decrypt_lat;
        bus.key_valid   = key_valid;
        bus.done        = done;
        bus.error       = error;
        bus.busy        = (state != ST_IDLE);
    end
endmodule

// File: tb/tb_rc6_control_seq.sv
// tb/tb_rc6_control_seq.sv - directed bench for rc6_control_seq across several round/key configurations
module tb_rc6_control_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    rc6_control_seq_if #(.ROUNDS(20)) b0 ();
    rc6_control_seq_if #(.ROUNDS(12)) b1 ();
    rc6_control_seq_if #(.ROUNDS(20)) b2 ();
    rc6_control_seq_if #(.ROUNDS(1))  b3 ();

    rc6_control_seq #(.ROUNDS(20), .KEY_WORDS(4))  u0 (.clk(clk), .rst(rst), .bus(b0));
    rc6_control_seq #(.ROUNDS(12), .KEY_WORDS(8))  u1 (.clk(clk), .rst(rst), .bus(b1));
    rc6_control_seq #(.ROUNDS(20), .KEY_WORDS(64)) u2 (.clk(clk), .rst(rst), .bus(b2));
    rc6_control_seq #(.ROUNDS(1),  .KEY_WORDS(4))  u3 (.clk(clk), .rst(rst), .bus(b3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic chk_cfg(input string name, input int t, input int s, input int r,
                           input logic kint, input logic dint, input logic m1, input logic m2,
                           input logic dn, input logic [31:0] ridx);
        logic in_round;
        in_round = (t > s) && (t <= s + r);
        chk({name, ".key_int_wr"},  kint, (t <= s));
        chk({name, ".data_int_wr"}, dint, in_round);
        chk({name, ".mode1"},       m1,   (t == s + 1));
        chk({name, ".mode2"},       m2,   (t == s + r));
        chk({name, ".done"},        dn,   (t == s + r + 1));
        chk({name, ".round_idx"},   ridx, in_round ? 32'(t - s) : 32'd0);
    endtask

    initial begin
        {b0.key_wr, b0.data_wr, b0.decrypt} = 3'b000;
        {b1.key_wr, b1.data_wr, b1.decrypt} = 3'b000;
        {b2.key_wr, b2.data_wr, b2.decrypt} = 3'b000;
        {b3.key_wr, b3.data_wr, b3.decrypt} = 3'b000;

        // reset state
        #4;
        chk("rst.busy",      b0.busy, 0);
        chk("rst.key_valid", b0.key_valid, 0);
        chk("rst.done",      b0.done, 0);
        chk("rst.error",     b0.error, 0);
        chk("rst.round_idx", b0.round_idx, 0);
        chk("rst.decrypt",   b0.decrypt_lat, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // key + data together, encrypt, default config
        @(posedge clk); #1;
        b0.key_wr = 1'b1; b0.data_wr = 1'b1; b0.decrypt = 1'b0;
        #3;
        chk("kd.t0.key_ext_wr",  b0.key_ext_wr, 1);
        chk("kd.t0.data_ext_wr", b0.data_ext_wr, 1);
        chk("kd.t0.busy",        b0.busy, 0);
        for (int t = 1; t <= 154; t++) begin
            @(posedge clk); #1;
            b0.key_wr = 1'b0; b0.data_wr = 1'b0;
            #3;
            chk("kd.key_ext_wr",  b0.key_ext_wr, 0);
            chk("kd.data_ext_wr", b0.data_ext_wr, 0);
            chk("kd.key_int_wr",  b0.key_int_wr, (t <= 132));
            chk("kd.data_int_wr", b0.data_int_wr, (t >= 133 && t <= 152));
            chk("kd.mode1",       b0.mode1, (t == 133));
            chk("kd.mode2",       b0.mode2, (t == 152));
            chk("kd.round_idx",   b0.round_idx, (t >= 133 && t <= 152) ? 32'(t - 132) : 32'd0);
            chk("kd.key_valid",   b0.key_valid, (t >= 133));
            chk("kd.done",        b0.done, (t == 153));
            chk("kd.busy",        b0.busy, (t <= 152));
            chk("kd.error",       b0.error, 0);
        end

        // data-only decrypt on the stored schedule
        @(posedge clk); #1;
        b0.data_wr = 1'b1; b0.decrypt = 1'b1;
        #3;
        chk("dec.t0.data_ext_wr", b0.data_ext_wr, 1);
        chk("dec.t0.key_ext_wr",  b0.key_ext_wr, 0);
        for (int t = 1; t <= 22; t++) begin
            @(posedge clk); #1;
            b0.data_wr = 1'b0; b0.decrypt = 1'b0;
            #3;
            chk("dec.key_int_wr",  b0.key_int_wr, 0);
            chk("dec.data_int_wr", b0.data_int_wr, (t <= 20));
            chk("dec.round_idx",   b0.round_idx, (t <= 20) ? 32'(21 - t) : 32'd0);
            chk("dec.mode1",       b0.mode1, (t == 1));
            chk("dec.mode2",       b0.mode2, (t == 20));
            chk("dec.decrypt",     b0.decrypt_lat, 1);
            chk("dec.done",        b0.done, (t == 21));
            chk("dec.busy",        b0.busy, (t <= 20));
            chk("dec.key_valid",   b0.key_valid, 1);
        end

        // reset, then data-only request is rejected
        @(posedge clk); #1 rst = 1'b1;
        #3;
        chk("rst2.key_valid", b0.key_valid, 0);
        chk("rst2.decrypt",   b0.decrypt_lat, 0);
        @(posedge clk); #1;
        rst = 1'b0; b0.data_wr = 1'b1;
        #3;
        chk("err.data_ext_wr", b0.data_ext_wr, 0);
        chk("err.error_t0",    b0.error, 0);
        @(posedge clk); #1;
        b0.data_wr = 1'b0;
        #3;
        chk("err.error_t1", b0.error, 1);
        chk("err.busy_t1",  b0.busy, 0);
        @(posedge clk); #4;
        chk("err.error_t2", b0.error, 0);
        chk("err.busy_t2",  b0.busy, 0);

        // key-only, with requests re-pulsed mid-schedule
        @(posedge clk); #1;
        b0.key_wr = 1'b1;
        #3;
        chk("ko.t0.key_ext_wr",  b0.key_ext_wr, 1);
        chk("ko.t0.data_ext_wr", b0.data_ext_wr, 0);
        for (int t = 1; t <= 134; t++) begin
            @(posedge clk); #1;
            b0.key_wr  = (t == 10);
            b0.data_wr = (t == 10);
            #3;
            chk("ko.key_ext_wr",  b0.key_ext_wr, 0);
            chk("ko.data_ext_wr", b0.data_ext_wr, 0);
            chk("ko.key_int_wr",  b0.key_int_wr, (t <= 132));
            chk("ko.data_int_wr", b0.data_int_wr, 0);
            chk("ko.done",        b0.done, 0);
            chk("ko.busy",        b0.busy, (t <= 132));
            chk("ko.key_valid",   b0.key_valid, (t >= 133));
        end

        // asynchronous reset in the middle of a schedule
        @(posedge clk); #1;
        b0.key_wr = 1'b1;
        #3;
        for (int t = 1; t <= 59; t++) begin
            @(posedge clk); #1;
            b0.key_wr = 1'b0;
            #3;
            chk("ar.key_valid", b0.key_valid, 0);
        end
        @(posedge clk); #3;
        chk("ar.t60.key_int_wr", b0.key_int_wr, 1);
        rst = 1'b1; b0.key_wr = 1'b1; b0.data_wr = 1'b1;
        #1;
        chk("ar.key_int_wr",  b0.key_int_wr, 0);
        chk("ar.key_ext_wr",  b0.key_ext_wr, 0);
        chk("ar.data_ext_wr", b0.data_ext_wr, 0);
        chk("ar.busy",        b0.busy, 0);
        chk("ar.key_valid",   b0.key_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0; b0.key_wr = 1'b0; b0.data_wr = 1'b1;
        #3;
        chk("ar.err.data_ext_wr", b0.data_ext_wr, 0);
        @(posedge clk); #1;
        b0.data_wr = 1'b0;
        #3;
        chk("ar.err.error", b0.error, 1);

        // other configurations: SCHED 84/192/18, rounds 12/20/1
        @(posedge clk); #1;
        {b1.key_wr, b1.data_wr} = 2'b11;
        {b2.key_wr, b2.data_wr} = 2'b11;
        {b3.key_wr, b3.data_wr} = 2'b11;
        #3;
        chk("c1.key_ext_wr", b1.key_ext_wr, 1);
        chk("c2.key_ext_wr", b2.key_ext_wr, 1);
        chk("c3.key_ext_wr", b3.key_ext_wr, 1);
        for (int t = 1; t <= 214; t++) begin
            @(posedge clk); #1;
            {b1.key_wr, b1.data_wr} = 2'b00;
            {b2.key_wr, b2.data_wr} = 2'b00;
            {b3.key_wr, b3.data_wr} = 2'b00;
            #3;
            chk_cfg("c1", t, 84, 12, b1.key_int_wr, b1.data_int_wr, b1.mode1, b1.mode2,
                    b1.done, 32'(b1.round_idx));
            chk_cfg("c2", t, 192, 20, b2.key_int_wr, b2.data_int_wr, b2.mode1, b2.mode2,
                    b2.done, 32'(b2.round_idx));
            chk_cfg("c3", t, 18, 1, b3.key_int_wr, b3.data_int_wr, b3.mode1, b3.mode2,
                    b3.done, 32'(b3.round_idx));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/rc6_control_seq.md
Name: rc6_control_seq

Overview:
Parametrised sequencer for the RC6 core: generates the key-register and data-round-register write strobes and mode flags for any round count and key length. Successor to the fixed 20-round / 128-bit-key controller. Adds stored-key reuse (data-only operations skip the key schedule), encrypt/decrypt direction with a round-key index, a completion pulse and an error pulse. Sits between the external write interface and the key/data datapath registers.

Parameters:
ROUNDS, 20, number of data rounds r (1..255)
KEY_WORDS, 4, key length c in 32-bit words (1..64)
Derived (localparam): SCHED = 3*max(KEY_WORDS, 2*ROUNDS+4); CW = $clog2(SCHED+1); RW = $clog2(ROUNDS+1)

Ports:
inClk  in  1  clock, all state on rising edge
inReset  in  1  asynchronous active-high reset
inKeyWr  in  1  request: load external key
inDataWr  in  1  request: load external data block
inDecrypt  in  1  direction for the accepted operation (1 = decrypt)
outKeyExtWr  out  1  key register loads external key
outKeyIntWr  out  1  key register schedule step
outDataExtWr  out  1  data register loads external block
outDataIntWr  out  1  data register round step
outMode1  out  1  first data round (whitening-in)
outMode2  out  1  last data round (whitening-out)
outRoundIdx  out  RW  round-key index of current data round
outDecrypt  out  1  direction latched for current operation
outKeyValid  out  1  stored schedule is complete and usable
outDone  out  1  one-cycle pulse, data operation finished
outError  out  1  one-cycle pulse, data request rejected
outBusy  out  1  operation in progress

Behaviour:
- Reset (async, any time, incl. mid-operation): state IDLE, counters 0, outKeyValid=0, outDone=0, outError=0, latched direction 0. All strobes 0 while reset is asserted.
- States: IDLE, SCHED, ROUND.
- IDLE acceptance (evaluated combinationally; transitions registered):
  - inKeyWr=1 (any inDataWr): outKeyExtWr=inKeyWr, outDataExtWr=inDataWr in the same cycle; next SCHED, count=1; outKeyValid cleared next edge; set pending-data flag = inDataWr; latch inDecrypt.
  - inKeyWr=0, inDataWr=1, outKeyValid=1: outDataExtWr=1; next ROUND, round=1; latch inDecrypt.
  - inKeyWr=0, inDataWr=1, outKeyValid=0: outDataExtWr=0, no state change; outError=1 next cycle for exactly one cycle.
- Outside IDLE, outKeyExtWr=outDataExtWr=0; inKeyWr/inDataWr/inDecrypt ignored (not queued).
- SCHED: outKeyIntWr=1 for exactly SCHED cycles (count 1..SCHED). After count=SCHED: outKeyValid=1; if pending-data go to ROUND round=1, else IDLE (no outDone).
- ROUND: outDataIntWr=1 for exactly ROUNDS cycles (round 1..ROUNDS). outMode1=1 only at round=1; outMode2=1 only at round=ROUNDS (both in the same cycle if ROUNDS=1). outRoundIdx = round (encrypt) or ROUNDS+1-round (decrypt); 0 outside ROUND. After round=ROUNDS go to IDLE; outDone=1 in the first IDLE cycle, one cycle only.
- outBusy=1 in SCHED and ROUND, 0 in IDLE (incl. the outDone cycle). A new request is accepted in the outDone cycle.
- outDecrypt holds the latched direction from acceptance until the next acceptance.
- Defaults: both requests together give key ext write at T0, outKeyIntWr T1..T132, outDataIntWr T133..T152, outMode1 at T133, outMode2 at T152 (same strobe timing as the previous controller); outDone at T153.
- Counters are sized CW/RW and never wrap. Terminal compares use exact equality to SCHED/ROUNDS.

Test Plan:
- Defaults; inKeyWr=inDataWr=1 for 1 cycle at T0 -> ext strobes at T0; KeyIntWr T1..T132; DataIntWr T133..T152; Mode1 T133; Mode2 T152; RoundIdx 1..20; outKeyValid rises T133; outDone T153; outBusy T1..T152.
- After the above, inDataWr=1 only, inDecrypt=1 -> DataIntWr for 20 cycles; RoundIdx 20..1; outDecrypt=1; outDone after 20 rounds; no KeyIntWr.
- After reset, inDataWr=1 only -> outDataExtWr=0, outError pulse 1 cycle, outBusy stays 0.
- inKeyWr only -> 132 KeyIntWr cycles, no DataIntWr, no outDone, outKeyValid=1; re-pulse inKeyWr and inDataWr during SCHED -> ignored.
- Reset asserted at T60 of a schedule -> all outputs 0 immediately, outKeyValid=0; a following data-only request -> outError.
- ROUNDS=12, KEY_WORDS=8 -> SCHED=84; ROUNDS=20, KEY_WORDS=64 -> SCHED=192; ROUNDS=1 -> Mode1 and Mode2 in the same cycle.
